// File: rtl/mips_reg_2w.sv
// mips_reg_2w: register file with two read ports and two byte-enabled write
// ports, per-register valid bits, optional write-to-read forwarding, a
// same-address write conflict flag and a saturating committed-lane counter.
module mips_reg_2w #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [ADDR_W-1:0]   R_Addr_A,
  input  logic [ADDR_W-1:0]   R_Addr_B,
  output logic [DATA_W-1:0]   R_Data_A,
  output logic [DATA_W-1:0]   R_Data_B,
  output logic                Valid_A,
  output logic                Valid_B,
  input  logic [ADDR_W-1:0]   W_Addr_0,
  input  logic [ADDR_W-1:0]   W_Addr_1,
  input  logic [DATA_W-1:0]   W_Data_0,
  input  logic [DATA_W-1:0]   W_Data_1,
  input  logic [DATA_W/8-1:0] W_BE_0,
  input  logic [DATA_W/8-1:0] W_BE_1,
  input  logic                Write_Reg_0,
  input  logic                Write_Reg_1,
  output logic                Conflict,
  output logic [15:0]         Write_Count
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic              r_conflict;
  logic [15:0]       r_count;

  logic              w_dis0, w_dis1;
  logic              w_com0, w_com1, w_same;
  logic [NB-1:0]     w_be0_eff, w_be1_eff;
  logic [DATA_W-1:0] w_mem_nxt [DEPTH];
  logic [DEPTH-1:0]  w_valid_nxt;
  logic [16:0]       w_add, w_sum;

  function automatic logic [16:0] f_pop(input logic [NB-1:0] v);
    logic [16:0] n;
    n = '0;
    for (int unsigned l = 0; l < NB; l++) n = n + 17'(v[l]);
    return n;
  endfunction

  // Writes to R0 are discarded when R0 is hardwired; Reset cancels all commits.
  assign w_dis0 = (ZERO_R0 != 0) && (W_Addr_0 == '0);
  assign w_dis1 = (ZERO_R0 != 0) && (W_Addr_1 == '0);
  assign w_com0 = Write_Reg_0 && !Reset && (|W_BE_0) && !w_dis0;
  assign w_com1 = Write_Reg_1 && !Reset && (|W_BE_1) && !w_dis1;
  assign w_same = w_com0 && w_com1 && (W_Addr_0 == W_Addr_1);

  // Port 0 only keeps lanes port 1 does not claim on a shared address, so the
  // same masks drive both the merge and the lane count.
  assign w_be0_eff = w_com0 ? (w_same ? (W_BE_0 & ~W_BE_1) : W_BE_0) : '0;
  assign w_be1_eff = w_com1 ? W_BE_1 : '0;

  assign w_add = f_pop(w_be0_eff) + f_pop(w_be1_eff);
  assign w_sum = {1'b0, r_count} + w_add;

  // Post-write image of every register; also the forwarding source for reads.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_mem_nxt[i]   = r_mem[i];
      w_valid_nxt[i] = r_valid[i];
      if (w_com0 && (W_Addr_0 == ADDR_W'(i))) begin
        w_valid_nxt[i] = 1'b1;
        for (int unsigned l = 0; l < NB; l++)
          if (w_be0_eff[l]) w_mem_nxt[i][8*l +: 8] = W_Data_0[8*l +: 8];
      end
      if (w_com1 && (W_Addr_1 == ADDR_W'(i))) begin
        w_valid_nxt[i] = 1'b1;
        for (int unsigned l = 0; l < NB; l++)
          if (w_be1_eff[l]) w_mem_nxt[i][8*l +: 8] = W_Data_1[8*l +: 8];
      end
    end
  end

  // State update: synchronous reset clears everything, else commit merged image.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_valid    <= '0;
      r_conflict <= 1'b0;
      r_count    <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= w_mem_nxt[i];
      r_valid    <= w_valid_nxt;
      r_conflict <= w_same;
      r_count    <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
  end

  // Read ports: zero latency, forwarded from the post-write image when enabled.
  always_comb begin
    if (BYPASS != 0) begin
      R_Data_A = w_mem_nxt[R_Addr_A];
      R_Data_B = w_mem_nxt[R_Addr_B];
      Valid_A  = w_valid_nxt[R_Addr_A];
      Valid_B  = w_valid_nxt[R_Addr_B];
    end else begin
      R_Data_A = r_mem[R_Addr_A];
      R_Data_B = r_mem[R_Addr_B];
      Valid_A  = r_valid[R_Addr_A];
      Valid_B  = r_valid[R_Addr_B];
    end
    if ((ZERO_R0 != 0) && (R_Addr_A == '0)) begin
      R_Data_A = '0;
      Valid_A  = 1'b1;
    end
    if ((ZERO_R0 != 0) && (R_Addr_B == '0)) begin
      R_Data_B = '0;
      Valid_B  = 1'b1;
    end
  end

  assign Conflict    = r_conflict;
  assign Write_Count = r_count;

endmodule

// File: tb/tb_mips_reg_2w.sv
// Directed bench for mips_reg_2w: a forwarding instance and a non-forwarding
// instance share all inputs; a vector table covers single-cycle behaviour and
// hand-written sequences cover reset state and counter saturation.
module tb_mips_reg_2w;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra, rb, a0, a1;
  logic [31:0] d0, d1;
  logic [3:0]  be0, be1;
  logic        we0, we1;

  logic [31:0] rda, rdb, rda_nb, rdb_nb;
  logic        va, vb, va_nb, vb_nb, conf, conf_nb;
  logic [15:0] cnt, cnt_nb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_reg_2w dut (
    .Clk(clk), .Reset(rst), .R_Addr_A(ra), .R_Addr_B(rb),
    .R_Data_A(rda), .R_Data_B(rdb), .Valid_A(va), .Valid_B(vb),
    .W_Addr_0(a0), .W_Addr_1(a1), .W_Data_0(d0), .W_Data_1(d1),
    .W_BE_0(be0), .W_BE_1(be1), .Write_Reg_0(we0), .Write_Reg_1(we1),
    .Conflict(conf), .Write_Count(cnt)
  );

  mips_reg_2w #(.BYPASS(0)) dut_nb (
    .Clk(clk), .Reset(rst), .R_Addr_A(ra), .R_Addr_B(rb),
    .R_Data_A(rda_nb), .R_Data_B(rdb_nb), .Valid_A(va_nb), .Valid_B(vb_nb),
    .W_Addr_0(a0), .W_Addr_1(a1), .W_Data_0(d0), .W_Data_1(d1),
    .W_BE_0(be0), .W_BE_1(be1), .Write_Reg_0(we0), .Write_Reg_1(we1),
    .Conflict(conf_nb), .Write_Count(cnt_nb)
  );

  typedef struct {
    logic        rst;
    logic        we0; logic [4:0] a0; logic [31:0] d0; logic [3:0] be0;
    logic        we1; logic [4:0] a1; logic [31:0] d1; logic [3:0] be1;
    logic [4:0]  ra;  logic [4:0] rb;
    logic [31:0] pre_a; logic pre_va; logic [31:0] pre_b; logic [31:0] pre_b_nb;
    logic [31:0] post_a; logic post_va; logic [31:0] post_b; logic post_vb;
    logic        post_conf; logic [15:0] post_cnt;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0;
    be0 = 4'h0; be1 = 4'h0; d0 = '0; d1 = '0; a0 = '0; a1 = '0;
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    rst = v.rst;
    we0 = v.we0; a0 = v.a0; d0 = v.d0; be0 = v.be0;
    we1 = v.we1; a1 = v.a1; d1 = v.d1; be1 = v.be1;
    ra = v.ra; rb = v.rb;
    #1;
    chk($sformatf("v%0d pre rda", idx), rda, v.pre_a);
    chk($sformatf("v%0d pre va", idx), 32'(va), 32'(v.pre_va));
    chk($sformatf("v%0d pre rdb", idx), rdb, v.pre_b);
    chk($sformatf("v%0d pre rdb_nobyp", idx), rdb_nb, v.pre_b_nb);
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    chk($sformatf("v%0d post rda", idx), rda, v.post_a);
    chk($sformatf("v%0d post va", idx), 32'(va), 32'(v.post_va));
    chk($sformatf("v%0d post rdb", idx), rdb, v.post_b);
    chk($sformatf("v%0d post vb", idx), 32'(vb), 32'(v.post_vb));
    chk($sformatf("v%0d post rdb_nobyp", idx), rdb_nb, v.post_b);
    chk($sformatf("v%0d post conflict", idx), 32'(conf), 32'(v.post_conf));
    chk($sformatf("v%0d post count", idx), 32'(cnt), 32'(v.post_cnt));
    chk($sformatf("v%0d post count_nobyp", idx), 32'(cnt_nb), 32'(v.post_cnt));
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    //               rst  we0  a0     d0             be0   we1  a1     d1             be1   ra     rb     pre_a          pre_va pre_b          pre_b_nb       post_a         post_va post_b         post_vb conf  cnt
    vecs[0]  = '{1'b0, 1'b1, 5'd1, 32'h2345_2345, 4'hF, 1'b0, 5'd0, 32'h0,         4'h0, 5'd1, 5'd1, 32'h2345_2345, 1'b1, 32'h2345_2345, 32'h0,         32'h2345_2345, 1'b1, 32'h2345_2345, 1'b1, 1'b0, 16'd4};
    vecs[1]  = '{1'b0, 1'b1, 5'd2, 32'hAAAA_AAAA, 4'hF, 1'b1, 5'd2, 32'h5555_5555, 4'h3, 5'd2, 5'd2, 32'hAAAA_5555, 1'b1, 32'hAAAA_5555, 32'h0,         32'hAAAA_5555, 1'b1, 32'hAAAA_5555, 1'b1, 1'b1, 16'd8};
    vecs[2]  = '{1'b0, 1'b1, 5'd3, 32'h1234_5678, 4'hF, 1'b0, 5'd0, 32'h0,         4'h0, 5'd2, 5'd3, 32'hAAAA_5555, 1'b1, 32'h1234_5678, 32'h0,         32'hAAAA_5555, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 16'd12};
    vecs[3]  = '{1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 4'hF, 1'b0, 5'd0, 32'h0,         4'h0, 5'd0, 5'd0, 32'h0,         1'b1, 32'h0,         32'h0,         32'h0,         1'b1, 32'h0,         1'b1, 1'b0, 16'd12};
    vecs[4]  = '{1'b0, 1'b1, 5'd6, 32'hDEAD_BEEF, 4'h0, 1'b0, 5'd0, 32'h0,         4'h0, 5'd6, 5'd6, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 16'd12};
    vecs[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,         4'h0, 1'b1, 5'd3, 32'hCAFE_0000, 4'hC, 5'd3, 5'd3, 32'hCAFE_5678, 1'b1, 32'hCAFE_5678, 32'h1234_5678, 32'hCAFE_5678, 1'b1, 32'hCAFE_5678, 1'b1, 1'b0, 16'd14};
    vecs[6]  = '{1'b0, 1'b1, 5'd7, 32'h1111_1111, 4'h1, 1'b1, 5'd7, 32'h2222_2222, 4'h2, 5'd7, 5'd7, 32'h0000_2211, 1'b1, 32'h0000_2211, 32'h0,         32'h0000_2211, 1'b1, 32'h0000_2211, 1'b1, 1'b1, 16'd16};
    vecs[7]  = '{1'b0, 1'b1, 5'd8, 32'h8888_8888, 4'hF, 1'b1, 5'd9, 32'h9999_9999, 4'hF, 5'd8, 5'd9, 32'h8888_8888, 1'b1, 32'h9999_9999, 32'h0,         32'h8888_8888, 1'b1, 32'h9999_9999, 1'b1, 1'b0, 16'd24};
    vecs[8]  = '{1'b0, 1'b1, 5'd4, 32'h4444_4444, 4'hF, 1'b1, 5'd4, 32'h0404_0404, 4'hF, 5'd4, 5'd4, 32'h0404_0404, 1'b1, 32'h0404_0404, 32'h0,         32'h0404_0404, 1'b1, 32'h0404_0404, 1'b1, 1'b1, 16'd28};
    vecs[9]  = '{1'b1, 1'b1, 5'd5, 32'h5555_5555, 4'hF, 1'b0, 5'd0, 32'h0,         4'h0, 5'd4, 5'd5, 32'h0404_0404, 1'b1, 32'h0,         32'h0,         32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 16'd0};
    vecs[10] = '{1'b0, 1'b1, 5'd5, 32'h5555_5555, 4'hF, 1'b0, 5'd0, 32'h0,         4'h0, 5'd5, 5'd4, 32'h5555_5555, 1'b1, 32'h0,         32'h0,         32'h5555_5555, 1'b1, 32'h0,         1'b0, 1'b0, 16'd4};
    vecs[11] = '{1'b0, 1'b1, 5'd0, 32'h1111_1111, 4'hF, 1'b1, 5'd0, 32'h2222_2222, 4'hF, 5'd0, 5'd0, 32'h0,         1'b1, 32'h0,         32'h0,         32'h0,         1'b1, 32'h0,         1'b1, 1'b0, 16'd4};

    idle_inputs();
    ra = 5'd1;
    rb = 5'd0;

    // Reset state.
    do_reset();
    #1;
    chk("reset rda", rda, 32'h0);
    chk("reset va", 32'(va), 32'h0);
    chk("reset r0 vb", 32'(vb), 32'h1);
    chk("reset conflict", 32'(conf), 32'h0);
    chk("reset count", 32'(cnt), 32'h0);

    for (int i = 0; i < NV; i++) apply(i, vecs[i]);

    // Counter saturation: 8191 dual full writes plus one single reaches FFFC.
    do_reset();
    for (int i = 0; i < 8191; i++) begin
      @(negedge clk);
      we0 = 1'b1; a0 = 5'd10; d0 = 32'(i); be0 = 4'hF;
      we1 = 1'b1; a1 = 5'd11; d1 = 32'(i); be1 = 4'hF;
      @(posedge clk);
    end
    @(negedge clk);
    we1 = 1'b0; be1 = 4'h0;
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    chk("sat preload", 32'(cnt), 32'h0000_FFFC);
    chk("sat preload nobyp", 32'(cnt_nb), 32'h0000_FFFC);

    @(negedge clk);
    we0 = 1'b1; a0 = 5'd12; d0 = 32'h0; be0 = 4'h3;
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    chk("sat two lanes", 32'(cnt), 32'h0000_FFFE);

    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      we0 = 1'b1; a0 = 5'd12; d0 = 32'h0; be0 = 4'hF;
      @(posedge clk);
      #1;
      idle_inputs();
      #1;
      chk($sformatf("sat full write %0d", k), 32'(cnt), 32'h0000_FFFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_reg_2w.md
MIPS_REG_2W -- requirements
Module: mips_reg_2w

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5, address width; depth SHALL be 2**ADDR_W registers.
REQ-003 Parameter BYPASS, default 1, write-to-read forwarding: 1 = enabled, 0 = disabled.
REQ-004 Parameter ZERO_R0, default 1; 1 = register 0 reads as zero and ignores writes.
REQ-005 Clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-006 Reset  in  1  synchronous reset, active-high, sampled on the rising edge of Clk.
REQ-007 R_Addr_A, R_Addr_B  in  ADDR_W  read port addresses.
REQ-008 R_Data_A, R_Data_B  out  DATA_W  read data, combinational from address and state.
REQ-009 Valid_A, Valid_B  out  1  addressed register has been written since the last reset.
REQ-010 W_Addr_0, W_Addr_1  in  ADDR_W  write port addresses.
REQ-011 W_Data_0, W_Data_1  in  DATA_W  write data.
REQ-012 W_BE_0, W_BE_1  in  DATA_W/8  byte enables; bit i covers bits 8i+7:8i.
REQ-013 Write_Reg_0, Write_Reg_1  in  1  write enables.
REQ-014 Conflict  out  1  registered flag: both ports wrote the same address on the previous edge.
REQ-015 Write_Count  out  16  registered count of committed byte-lane writes, saturating.

Function
REQ-016 A port SHALL commit on a rising edge when Write_Reg_n=1, Reset=0 and W_BE_n is nonzero; only the enabled lanes SHALL change.
REQ-017 A write with W_BE_n all-zero SHALL change no register and no Valid bit.
REQ-018 With ZERO_R0=1, writes to address 0 SHALL be discarded and R_Data for address 0 SHALL be 0; Valid for address 0 SHALL be 1.
REQ-019 Same-address simultaneous writes: port 1 SHALL win on every lane enabled in W_BE_1; port 0 SHALL supply the lanes enabled only in W_BE_0.
REQ-020 Conflict SHALL be 1 for exactly the cycle after an edge where both ports committed to the same non-discarded address, otherwise 0.
REQ-021 Read latency SHALL be zero cycles: R_Data reflects the stored value after the most recent edge.
REQ-022 With BYPASS=1, if R_Addr_x matches a committing write address in the same cycle, R_Data_x SHALL show the merged post-write value, using the REQ-019 priority, before the edge.
REQ-023 With BYPASS=0, R_Data_x SHALL show the stored pre-write value until the edge.
REQ-024 Valid bit per register SHALL set on its first commit and SHALL be bypassed like data when BYPASS=1.
REQ-025 Write_Count SHALL add the popcount of the committed enables of both ports each edge and SHALL saturate at 16'hFFFF without wrapping. Enables of discarded writes and lanes overwritten by port 1 under REQ-019 SHALL NOT be counted.
REQ-026 Read ports SHALL be independent; both may address the same register.

Reset
REQ-027 On an edge with Reset=1, every register SHALL become 0, every Valid bit 0 (except R0 per REQ-018), Conflict 0 and Write_Count 0.
REQ-028 Writes presented in a Reset cycle SHALL be ignored and bypass SHALL be suppressed while Reset=1; outputs SHALL show reset values from the following cycle.
REQ-029 A reset in the middle of a write stream SHALL cancel only that cycle's writes; writes in later cycles SHALL proceed normally.

Verification
REQ-030 Reset, then write port 0 to addr 1 with 32'h2345_2345, BE=4'hF -> after the edge, R_Addr_A=1 gives 32'h2345_2345 and Valid_A=1; Write_Count=4.
REQ-031 Port 0 writes addr 2 with 32'hAAAA_AAAA, BE=4'hF, and port 1 writes addr 2 with 32'h5555_5555, BE=4'h3, on the same edge -> R_Data=32'hAAAA_5555; Conflict=1 for one cycle; Write_Count increases by 4.
REQ-032 BYPASS=1: write addr 3 with 32'h1234_5678 while R_Addr_B=3 -> R_Data_B=32'h1234_5678 before the edge. BYPASS=0 -> the old value 0 is shown until the edge.
REQ-033 Write addr 0 with 32'hFFFF_FFFF -> R_Data for addr 0 stays 0; Write_Count is unchanged.
REQ-034 Write addr 4, then assert Reset together with a write to addr 5 -> addr 4 and addr 5 read 0, Valid=0, Write_Count=0.
REQ-035 Preload Write_Count to 16'hFFFC via writes, then issue two full writes -> Write_Count=16'hFFFF and remains there on further writes.
